// File: rtl/varredura_display7seg.sv
// Multiplexed 7-segment scan controller: one shared decoder, blanking gap between
// digits, double-buffered digit codes. Optional macro: LEADING_ZERO_BLANK_EN.
//
// state | meaning
// IDLE  | display off, waiting for enable
// BLANK | all digits off for BLANK_CYCLES (anti-ghosting gap)
// SHOW  | digit idx lit for DIV_MAX+1 cycles
module varredura_display7seg #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_WIDTH    = 16,
  parameter int DIV_MAX      = 4999,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_WIDTH-1:0] DWELL_LOAD = DIV_WIDTH'(DIV_MAX);
  localparam logic [DIV_WIDTH-1:0] BLANK_LOAD = DIV_WIDTH'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                         state_q, state_nxt;
  logic [IDX_W-1:0]               idx_q, idx_nxt;
  logic [DIV_WIDTH-1:0]           cnt_q, cnt_nxt;
  logic [NUM_DIGITS-1:0][3:0]     pending_q, shadow_q;
  logic                           dirty_q;
  logic [6:0]                     seg_nxt;
  logic [NUM_DIGITS-1:0]          an_nxt;
  logic                           frame_start_nxt;
  logic                           frame_edge;
  logic [NUM_DIGITS-1:0]          upper_zero;
  logic                           lz_blank;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1111011;
      default: decode = 7'b0000001;
    endcase
  endfunction

  // upper_zero[i]: digit i and every more-significant digit hold code 0
  always_comb begin
    upper_zero = '0;
    upper_zero[NUM_DIGITS-1] = (shadow_q[NUM_DIGITS-1] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (shadow_q[i] == 4'd0);
    end
  end

  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    cnt_nxt   = cnt_q;
    if (!enable) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_nxt = BLANK;
          idx_nxt   = '0;
          cnt_nxt   = BLANK_LOAD;
        end
        BLANK: begin
          if (cnt_q == '0) begin
            state_nxt = SHOW;
            cnt_nxt   = DWELL_LOAD;
          end else begin
            cnt_nxt = cnt_q - DIV_WIDTH'(1);
          end
        end
        SHOW: begin
          if (cnt_q == '0) begin
            state_nxt = BLANK;
            cnt_nxt   = BLANK_LOAD;
            idx_nxt   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          end else begin
            cnt_nxt = cnt_q - DIV_WIDTH'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end

    frame_edge      = (state_nxt == BLANK) && (state_q != BLANK) && (idx_nxt == '0);
    frame_start_nxt = (state_q == BLANK) && (state_nxt == SHOW) && (idx_nxt == '0);

`ifdef LEADING_ZERO_BLANK_EN
    lz_blank = upper_zero[idx_nxt] && (idx_nxt != '0);
`else
    lz_blank = 1'b0;
`endif

    an_nxt  = '0;
    seg_nxt = '0;
    if (state_nxt == SHOW) begin
      an_nxt[idx_nxt] = 1'b1;
      seg_nxt         = lz_blank ? 7'b0000000 : decode(shadow_q[idx_nxt]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      pending_q   <= '0;
      shadow_q    <= '0;
      dirty_q     <= 1'b0;
      seg         <= '0;
      an          <= '0;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      idx_q       <= idx_nxt;
      cnt_q       <= cnt_nxt;
      seg         <= seg_nxt;
      an          <= an_nxt;
      frame_start <= frame_start_nxt;
      if (load) pending_q <= digits;
      // Frame boundary: a coincident load bypasses pending so the newest data wins
      if (frame_edge) begin
        if (load)         shadow_q <= digits;
        else if (dirty_q) shadow_q <= pending_q;
        dirty_q <= 1'b0;
      end else if (load) begin
        dirty_q <= 1'b1;
      end
    end
  end

endmodule
